// File: rtl/if_prefetch_queue_pkg.sv
// rtl/if_prefetch_queue_pkg.sv - shared types and constants for the instruction prefetch queue
package if_prefetch_queue_pkg;

    localparam int          WORD_W = 32;
    localparam logic [31:0] NOP    = 32'h0;
    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc4;
    } q_entry_t;

    function automatic logic [WORD_W-1:0] pc_plus4(input logic [WORD_W-1:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/if_prefetch_queue_if.sv
// rtl/if_prefetch_queue_if.sv - instruction memory req/ack bus
interface if_prefetch_queue_if;
    import if_prefetch_queue_pkg::*;

    logic              req;
    logic [WORD_W-1:0] addr;
    logic              ack;
    logic [WORD_W-1:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/if_prefetch_queue_pf_fifo.sv
// rtl/if_prefetch_queue_pf_fifo.sv - DEPTH-entry fetch queue with flush and combinational head
module if_prefetch_queue_pf_fifo
    import if_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  q_entry_t                 push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output q_entry_t                 head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    q_entry_t        mem [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;

    // Pointer and occupancy bookkeeping; flush empties the queue without touching storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= tail;
            count <= '0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage; written at the tail, never needs reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push && !flush) mem[tail] <= push_data;
    end

    assign head_data = mem[head];

endmodule

// File: rtl/if_prefetch_queue.sv
// rtl/if_prefetch_queue.sv - instruction fetch front-end with prefetch queue and redirect flush
module if_prefetch_queue
    import if_prefetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                redirect_valid,
    input  logic [WORD_W-1:0]   redirect_pc,
    input  logic                stall,
    output logic                out_valid,
    output logic [WORD_W-1:0]   out_instr,
    output logic [WORD_W-1:0]   out_pc4,
    if_prefetch_queue_if.master imem
);

    localparam int             CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    fetch_state_t       state;
    logic [WORD_W-1:0]  fetch_pc;
    logic [CW-1:0]      count;
    logic [CW-1:0]      count_after;
    q_entry_t           head_data;
    q_entry_t           push_data;
    logic               push;
    logic               pop;

    // A redirect kills both the word arriving this cycle and the head consumption
    assign push        = (state == ST_FETCH) && imem.ack && !redirect_valid;
    assign pop         = out_valid && !stall && !redirect_valid;
    assign count_after = count + CW'(push) - CW'(pop);
    assign push_data   = '{instr: imem.rdata, pc4: pc_plus4(fetch_pc)};

    if_prefetch_queue_pf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head_data (head_data)
    );

    // Fetch FSM: owns fetch_pc and the registered req/addr handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            fetch_pc  <= RESET_PC;
            imem.req  <= 1'b0;
            imem.addr <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            if (state != ST_IDLE && !imem.ack) begin
                // request still open: address must hold until the stale ack arrives
                state <= ST_DISCARD;
            end else begin
                state     <= ST_FETCH;
                imem.req  <= 1'b1;
                imem.addr <= redirect_pc;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (count < FULL) begin
                        state     <= ST_FETCH;
                        imem.req  <= 1'b1;
                        imem.addr <= fetch_pc;
                    end
                end
                ST_FETCH: begin
                    if (imem.ack) begin
                        fetch_pc <= pc_plus4(fetch_pc);
                        if (count_after < FULL) begin
                            imem.addr <= pc_plus4(fetch_pc);
                        end else begin
                            state    <= ST_IDLE;
                            imem.req <= 1'b0;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (imem.ack) begin
                        state     <= ST_FETCH;
                        imem.addr <= fetch_pc;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    imem.req <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = (count != '0);
    assign out_instr = out_valid ? head_data.instr : NOP;
    assign out_pc4   = out_valid ? head_data.pc4   : '0;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb/tb_if_prefetch_queue.sv - directed self-checking bench for if_prefetch_queue
module tb_if_prefetch_queue;
    import if_prefetch_queue_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;

    int errors = 0;
    int checks = 0;
    int lat = 0;
    int wait_cnt = 0;
    bit seen;

    if_prefetch_queue_if imem();

    if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc4        (out_pc4),
        .imem           (imem)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        redirect_valid = 1'b0;
        stall = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Instruction memory: ack after lat wait cycles, data derived from the address
    initial begin
        imem.ack = 1'b0;
        imem.rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (imem.req) begin
                if (wait_cnt == lat) begin
                    imem.ack = 1'b1;
                    imem.rdata = word_at(imem.addr);
                    wait_cnt = 0;
                end else begin
                    imem.ack = 1'b0;
                    imem.rdata = 32'hBAD0_BAD0;
                    wait_cnt++;
                end
            end else begin
                imem.ack = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    initial begin
        // 1: reset values, then back-to-back streaming with zero-wait memory
        lat = 0;
        step();
        check_eq("rst_req", 32'(imem.req), 32'd0);
        check_eq("rst_addr", imem.addr, 32'h0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_instr", out_instr, 32'h0);
        check_eq("rst_pc4", out_pc4, 32'h0);
        reset = 1'b1;
        step();
        check_eq("t1_req", 32'(imem.req), 32'd1);
        check_eq("t1_addr0", imem.addr, 32'h0);
        check_eq("t1_valid0", 32'(out_valid), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            step();
            check_eq("t1_addr", imem.addr, 32'(4 * k));
            check_eq("t1_valid", 32'(out_valid), 32'd1);
            check_eq("t1_pc4", out_pc4, 32'(4 * k));
            check_eq("t1_instr", out_instr, word_at(32'(4 * k - 4)));
        end

        // 2: stall fills the queue, then drains in order and fetch resumes at 0x10
        do_reset();
        stall = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i > 5) begin
                check_eq("t2_req_low", 32'(imem.req), 32'd0);
                check_eq("t2_instr_hold", out_instr, word_at(32'h0));
            end
        end
        check_eq("t2_pc4_hold", out_pc4, 32'h4);
        stall = 1'b0;
        step();
        check_eq("t2_drain1", out_pc4, 32'h8);
        check_eq("t2_req_idle", 32'(imem.req), 32'd0);
        step();
        check_eq("t2_drain2", out_pc4, 32'hC);
        check_eq("t2_resume_req", 32'(imem.req), 32'd1);
        check_eq("t2_resume_addr", imem.addr, 32'h10);
        step();
        check_eq("t2_drain3", out_pc4, 32'h10);
        step();
        check_eq("t2_new_pc4", out_pc4, 32'h14);
        check_eq("t2_new_instr", out_instr, word_at(32'h10));

        // 3: three wait states, request held stable, exactly one push per ack
        do_reset();
        stall = 1'b1;
        lat = 3;
        for (int i = 1; i <= 4; i++) begin
            step();
            check_eq("t3_req", 32'(imem.req), 32'd1);
            check_eq("t3_addr", imem.addr, 32'h0);
            check_eq("t3_valid", 32'(out_valid), 32'd0);
        end
        step();
        check_eq("t3_valid1", 32'(out_valid), 32'd1);
        check_eq("t3_pc4", out_pc4, 32'h4);
        check_eq("t3_next_addr", imem.addr, 32'h4);
        repeat (4) step();
        check_eq("t3_head_hold", out_pc4, 32'h4);
        check_eq("t3_addr8", imem.addr, 32'h8);
        stall = 1'b0;
        step();
        check_eq("t3_second", out_pc4, 32'h8);
        step();
        check_eq("t3_empty", 32'(out_valid), 32'd0);

        // 4: redirect while request pending; stale data dropped
        do_reset();
        lat = 3;
        step();
        check_eq("t4_req", 32'(imem.req), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        check_eq("t4_valid0", 32'(out_valid), 32'd0);
        check_eq("t4_req_hold", 32'(imem.req), 32'd1);
        check_eq("t4_addr_hold", imem.addr, 32'h0);
        step();
        check_eq("t4_addr_hold2", imem.addr, 32'h0);
        step();
        check_eq("t4_addr_hold3", imem.addr, 32'h0);
        step();
        check_eq("t4_new_addr", imem.addr, 32'h40);
        check_eq("t4_no_stale", 32'(out_valid), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        check_eq("t4_got_output", 32'(seen), 32'd1);
        check_eq("t4_pc4", out_pc4, 32'h44);
        check_eq("t4_instr", out_instr, word_at(32'h40));

        // 5: redirect coinciding with ack and pop
        do_reset();
        lat = 0;
        repeat (4) step();
        check_eq("t5_pre_pc4", out_pc4, 32'hC);
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        step();
        redirect_valid = 1'b0;
        check_eq("t5_flushed", 32'(out_valid), 32'd0);
        check_eq("t5_addr", imem.addr, 32'h80);
        check_eq("t5_req", 32'(imem.req), 32'd1);
        step();
        check_eq("t5_pc4", out_pc4, 32'h84);
        check_eq("t5_instr", out_instr, word_at(32'h80));

        // 6: asynchronous reset mid-fetch, restart, then fetch_pc wrap
        do_reset();
        stall = 1'b1;
        repeat (3) step();
        check_eq("t6_pre_valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("t6_async_req", 32'(imem.req), 32'd0);
        check_eq("t6_async_addr", imem.addr, 32'h0);
        check_eq("t6_async_valid", 32'(out_valid), 32'd0);
        check_eq("t6_async_instr", out_instr, 32'h0);
        check_eq("t6_async_pc4", out_pc4, 32'h0);
        stall = 1'b0;
        step();
        reset = 1'b1;
        step();
        check_eq("t6_restart_addr", imem.addr, 32'h0);
        check_eq("t6_restart_req", 32'(imem.req), 32'd1);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        check_eq("t6_redir_addr", imem.addr, 32'hFFFF_FFF8);
        step();
        check_eq("t6_pc4_fc", out_pc4, 32'hFFFF_FFFC);
        check_eq("t6_addr_fc", imem.addr, 32'hFFFF_FFFC);
        step();
        check_eq("t6_pc4_wrap", out_pc4, 32'h0);
        check_eq("t6_instr_fc", out_instr, word_at(32'hFFFF_FFFC));
        check_eq("t6_addr_wrap", imem.addr, 32'h0);
        step();
        check_eq("t6_pc4_after", out_pc4, 32'h4);
        check_eq("t6_instr_0", out_instr, word_at(32'h0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
